// File: rtl/msu_sector_responder_if.sv
// msu_sector_responder_if: sd_rd/sd_ack/sd_buff_wr sector bus plus the word-addressed memory port.
`timescale 1ns/1ps
interface msu_sector_responder_if #(
    parameter int LBA_W  = 21,
    parameter int MEM_AW = 29
);
    logic              sd_rd;
    logic [LBA_W-1:0]  sd_lba;
    logic              sd_ack;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_addr;
    logic [15:0]       sd_buff_dout;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [15:0]       mem_dout;
    modport master (
        output sd_rd, sd_lba, mem_ready, mem_dout,
        input  sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_rd
    );
    modport slave (
        input  sd_rd, sd_lba, mem_ready, mem_dout,
        output sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_addr, mem_rd
    );
endinterface

// File: rtl/msu_sector_responder.sv
// msu_sector_responder: answers sd_rd with one 256-word sector streamed from word-addressed memory.
// MSU_RESP_STATS_EN adds sectors_served / last_lba statistics ports.
`timescale 1ns/1ps
module msu_sector_responder #(
    parameter int LBA_W  = 21,
    parameter int MEM_AW = 29,
    parameter int WR_GAP = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    msu_sector_responder_if.slave bus,
    input  logic [31:0]          img_size,
    output logic                 busy,
    output logic                 oob
`ifdef MSU_RESP_STATS_EN
    ,
    output logic [15:0]          sectors_served,
    output logic [LBA_W-1:0]     last_lba
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, GAP, DONE} state_t;
    state_t           state, nxt;
    logic [LBA_W-1:0] lba;
    logic [7:0]       widx;
    logic [15:0]      word;
    logic [15:0]      gap_cnt;
    logic [31:0]      b;
    logic             in_range, fetch_done, last_gap, accept;
    // {lba, widx, 1'b0} is exactly {lba,9'b0} + 2*widx
    always_comb begin
        b          = 32'({lba, widx, 1'b0});
        in_range   = b < img_size;
        fetch_done = state == FETCH && (!in_range || bus.mem_ready);
        last_gap   = gap_cnt == 16'(WR_GAP - 1);
        accept     = state == IDLE && bus.sd_rd;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.sd_rd ? FETCH : IDLE;
            FETCH:   nxt = fetch_done ? WRITE : FETCH;
            WRITE:   nxt = widx == 8'hFF ? DONE : (WR_GAP == 0 ? FETCH : GAP);
            GAP:     nxt = last_gap ? FETCH : GAP;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.sd_ack       = state inside {FETCH, WRITE, GAP};
        busy             = state inside {FETCH, WRITE, GAP};
        bus.sd_buff_wr   = state == WRITE;
        bus.sd_buff_addr = widx;
        bus.sd_buff_dout = word;
        bus.mem_rd       = state == FETCH && in_range;
        bus.mem_addr     = MEM_AW'({lba, widx});
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lba     <= '0;
            widx    <= '0;
            word    <= '0;
            gap_cnt <= '0;
            oob     <= 1'b0;
        end else begin
            oob <= accept && 32'({bus.sd_lba, 9'b0}) >= img_size;
            if (accept) begin
                lba  <= bus.sd_lba;
                widx <= '0;
            end
            // odd-length image: the final byte shares its word with zero padding
            if (fetch_done)
                word <= !in_range ? 16'h0000 :
                        (b + 32'd1 == img_size ? {8'h00, bus.mem_dout[7:0]} : bus.mem_dout);
            if (state == WRITE && widx != 8'hFF) widx <= widx + 8'd1;
            gap_cnt <= state == GAP ? gap_cnt + 16'd1 : 16'h0000;
        end
    end
`ifdef MSU_RESP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sectors_served <= '0;
            last_lba       <= '0;
        end else begin
            if (state == DONE) sectors_served <= sectors_served + 16'd1;
            if (accept) last_lba <= bus.sd_lba;
        end
    end
`endif
endmodule

// File: tb/tb_msu_sector_responder.sv
// tb_msu_sector_responder: randomized requests against a byte-level sector model, scoreboard-checked.
`timescale 1ns/1ps
module tb_msu_sector_responder;
    localparam int LBA_W  = 21;
    localparam int MEM_AW = 29;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] img_size = '0;
    logic        busy, oob;
`ifdef MSU_RESP_STATS_EN
    logic [15:0]      sectors_served;
    logic [LBA_W-1:0] last_lba;
`endif
    msu_sector_responder_if #(.LBA_W(LBA_W), .MEM_AW(MEM_AW)) bus();
    msu_sector_responder #(.LBA_W(LBA_W), .MEM_AW(MEM_AW), .WR_GAP(0)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .img_size(img_size),
        .busy(busy),
        .oob(oob)
`ifdef MSU_RESP_STATS_EN
        ,
        .sectors_served(sectors_served),
        .last_lba(last_lba)
`endif
    );
    always #5 clk = ~clk;
    logic [15:0] mem [2048];
    logic [23:0] exp_q [$];
    int          vectors = 0, miscompares = 0;
    int          hs_cnt = 0, wr_cnt = 0;
    int          exp_base = 0;
    bit          rand_ready = 1'b0;
    int          stall_word = -1, stall_left = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // memory: answers just after each edge so the DUT sees stable ready/data
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_dout  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_rd && stall_left > 0 && int'(bus.mem_addr[7:0]) == stall_word) begin
                bus.mem_ready = 1'b0;
                stall_left--;
            end else
                bus.mem_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.mem_dout = bus.mem_ready ? mem[bus.mem_addr[10:0]] : 16'($urandom);
        end
    end
    // monitor: checks memory addressing and pops the scoreboard on each strobe
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.mem_rd) begin
                    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_base + hs_cnt));
                    if (bus.mem_ready) hs_cnt++;
                end
                if (bus.sd_buff_wr) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_strobe: got addr %0d with no word expected", bus.sd_buff_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("buff_addr", 32'(bus.sd_buff_addr), 32'(e[23:16]));
                        chk("buff_dout", 32'(bus.sd_buff_dout), 32'(e[15:0]));
                    end
                end
            end
        end
    end
    // model: each word covers file bytes lba*512+2w and +1; bytes at or past img are zero
    task automatic load_expect(input int lba, input int img, output int n_in);
        int          bt;
        logic [15:0] d;
        n_in = 0;
        for (int w = 0; w < 256; w++) begin
            bt = lba * 512 + 2 * w;
            if (bt >= img) d = 16'h0000;
            else if (bt + 1 == img) d = {8'h00, mem[lba * 256 + w][7:0]};
            else d = mem[lba * 256 + w];
            if (bt < img) n_in++;
            exp_q.push_back({8'(w), d});
        end
    endtask
    task automatic issue(input int lba, input int img, output int n_in);
        @(negedge clk);
        img_size   = 32'(img);
        bus.sd_lba = LBA_W'(lba);
        exp_base   = lba * 256;
        hs_cnt     = 0;
        wr_cnt     = 0;
        load_expect(lba, img, n_in);
        bus.sd_rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sd_rd = 1'b0;
        chk("ack_at_t1", 32'(bus.sd_ack), 32'd1);
        chk("busy_at_t1", 32'(busy), 32'd1);
        chk("oob_at_t1", 32'(oob), 32'(lba * 512 >= img));
    endtask
    task automatic run_req(input int lba, input int img, input int exp_cyc);
        int cyc, n_in;
        issue(lba, img, n_in);
        cyc = 1;
        while (bus.sd_ack && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                chk("oob_one_cycle", 32'(oob), 32'd0);
                if (exp_cyc != 0) chk("first_strobe_t2", 32'(bus.sd_buff_wr), 32'd1);
            end
        end
        if (bus.sd_ack) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: sd_ack still high after %0d cycles", cyc);
        end
        if (exp_cyc != 0) chk("ack_fall_cycle", 32'(cyc), 32'(exp_cyc));
        chk("busy_done", 32'(busy), 32'd0);
        chk("strobe_count", 32'(wr_cnt), 32'd256);
        chk("mem_handshakes", 32'(hs_cnt), 32'(n_in));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask
    initial begin
        int cyc, n_in;
        bus.sd_rd  = 1'b0;
        bus.sd_lba = '0;
        for (int k = 0; k < 2048; k++) mem[k] = 16'(k);
        #1 reset = 1'b1;
        #1;
        chk("rst_ack", 32'(bus.sd_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(bus.sd_buff_wr), 32'd0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_dout", 32'(bus.sd_buff_dout), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run_req(1, 1024, 513);
        run_req(1, 600, 513);
        mem[344] = 16'hABCD;
        run_req(1, 601, 513);
        run_req(5, 1024, 513);
        stall_word = 3;
        stall_left = 10;
        run_req(2, 2048, 523);
        chk("stall_consumed", 32'(stall_left), 32'd0);
        stall_word = -1;
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2048; k++) mem[k] = 16'($urandom);
            run_req($urandom_range(0, 5), $urandom_range(0, 3500), 0);
        end
        rand_ready = 1'b0;
        for (int k = 0; k < 2048; k++) mem[k] = 16'($urandom);
        issue(2, 2048, n_in);
        cyc = 0;
        while (!(bus.sd_buff_wr && bus.sd_buff_addr == 8'd100) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_word_100", 32'(bus.sd_buff_addr), 32'd100);
        #2 reset = 1'b1;
        #1;
        chk("abort_strobes", 32'(wr_cnt), 32'd101);
        chk("abort_ack", 32'(bus.sd_ack), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr", 32'(bus.sd_buff_wr), 32'd0);
        chk("abort_addr", 32'(bus.sd_buff_addr), 32'd0);
        chk("abort_dout", 32'(bus.sd_buff_dout), 32'd0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run_req(0, 1024, 513);
`ifdef MSU_RESP_STATS_EN
        chk("sectors_served", 32'(sectors_served), 32'd1);
        chk("last_lba", 32'(last_lba), 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
